aes_hex_uart_formatter: RTL

Upstream feeder for the byte-wide UART transmitter. Accepts one AES result block (default 128 bits) over a valid/ready handshake and converts it to uppercase ASCII hex, most-significant nibble first. It then issues one character per UART write, paced by the UART busy flag, and optionally terminates the line with CR LF. It sits between the AES core output and the UART transmitter, so cipher results appear as readable text on a serial terminal.

---
 rtl/aes_hex_uart_formatter_if.sv | 30 +++
 rtl/aes_hex_uart_formatter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/aes_hex_uart_formatter_if.sv
// ---------------------------------------------------------------------------
// aes_hex_uart_formatter_if
// Bundles the block handshake and the UART write port of the hex formatter.
//   blk_valid_i / blk_ready_o / blk_data_i : AES result block handshake
//   uart_wr_o / uart_dat_o / uart_busy_i   : byte-wide UART transmitter port
//   done_o                                 : end-of-block pulse
// slave  : formatter side
// master : block producer / UART / observer side
// ---------------------------------------------------------------------------
interface aes_hex_uart_formatter_if #(
    parameter int unsigned NBYTES = 16
) ();
    logic                  blk_valid_i;
    logic [8*NBYTES-1:0]   blk_data_i;
    logic                  blk_ready_o;
    logic                  uart_wr_o;
    logic [7:0]            uart_dat_o;
    logic                  uart_busy_i;
    logic                  done_o;

    modport slave (
        input  blk_valid_i, blk_data_i, uart_busy_i,
        output blk_ready_o, uart_wr_o, uart_dat_o, done_o
    );

    modport master (
        output blk_valid_i, blk_data_i, uart_busy_i,
        input  blk_ready_o, uart_wr_o, uart_dat_o, done_o
    );
endinterface

// File: rtl/aes_hex_uart_formatter.sv
// ---------------------------------------------------------------------------
// aes_hex_uart_formatter
// Takes one AES result block and prints it to the UART as uppercase ASCII
// hex, most-significant nibble first, optionally followed by CR LF.
// One character per write strobe; each strobe is followed by a guard cycle
// and then the formatter waits for the UART busy flag to drop.
// Ports:
//   sys_clk_i  : system clock
//   sys_rstn_i : asynchronous active-low reset
//   bus        : block handshake, UART write port and done pulse (slave)
// ---------------------------------------------------------------------------
module aes_hex_uart_formatter #(
    parameter int unsigned NBYTES = 16,
    parameter bit          EOL_EN = 1'b1
) (
    input  logic                      sys_clk_i,
    input  logic                      sys_rstn_i,
    aes_hex_uart_formatter_if.slave   bus
);
    localparam int unsigned NHEX   = 2 * NBYTES;
    localparam int unsigned NCHARS = NHEX + (EOL_EN ? 2 : 0);
    localparam int unsigned IW     = $clog2(NCHARS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHARS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_HOLD,
        S_WAIT,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [8*NBYTES-1:0] blk_q, blk_d;
    logic [7:0]          dat_q, dat_d;
    logic [IW-1:0]       idx_inc;

    // Character at position idx of a block: hex digits first, then CR, LF.
    function automatic logic [7:0] char_of(input logic [8*NBYTES-1:0] blk,
                                           input logic [IW-1:0]       idx);
        logic [3:0] nib;
        logic [7:0] ch;
        nib = '0;
        if (32'(idx) < NHEX) begin
            nib = 4'(blk >> (4 * (NHEX - 1 - 32'(idx))));
            ch  = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end else if (32'(idx) == NHEX) begin
            ch = 8'h0D;
        end else begin
            ch = 8'h0A;
        end
        return ch;
    endfunction

    assign idx_inc = idx_q + IW'(1);

    // The character register is loaded on every transition into SEND, so the
    // byte is already valid in the strobe cycle and holds until the next one.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        blk_d           = blk_q;
        dat_d           = dat_q;
        bus.blk_ready_o = 1'b0;
        bus.uart_wr_o   = 1'b0;
        bus.done_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.blk_ready_o = 1'b1;
                if (bus.blk_valid_i) begin
                    blk_d   = bus.blk_data_i;
                    idx_d   = '0;
                    dat_d   = char_of(bus.blk_data_i, '0);
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                bus.uart_wr_o = 1'b1;
                state_d       = S_HOLD;
            end
            S_HOLD: begin
                // UART busy rises one cycle after the strobe; do not sample yet.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.uart_busy_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_inc;
                        dat_d   = char_of(blk_q, idx_inc);
                        state_d = S_SEND;
                    end
                end
            end
            S_DONE: begin
                bus.done_o = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            blk_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            blk_q   <= blk_d;
            dat_q   <= dat_d;
        end
    end

    assign bus.uart_dat_o = dat_q;

endmodule
